axis_frame_arbiter: RTL and testbench

Two-source AXI-Stream image arbiter that shares a single downstream pipelined datapath between two video sources. It grants the output one whole frame at a time, switching only on frame boundaries, with round-robin fairness between sources. Output is driven through one registered slice with full valid/ready backpressure. Orphan beats that arrive outside a frame are discarded and counted. It sits between the image sources and the pipelined register/processing chain.

---
 rtl/axis_frame_arbiter.sv | 165 ++++++++++++++++
 tb/tb_axis_frame_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - two-source frame-granular AXI-Stream arbiter with registered output slice
module axis_frame_arbiter #(
   parameter int DATA_BITS       = 24,
   parameter int LINES_PER_FRAME = 480
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DATA_BITS-1:0] axis_s0_data_i,
   input  logic                 axis_s0_valid_i,
   output logic                 axis_s0_ready_o,
   input  logic                 axis_s0_last_i,
   input  logic                 axis_s0_user_i,
   input  logic [DATA_BITS-1:0] axis_s1_data_i,
   input  logic                 axis_s1_valid_i,
   output logic                 axis_s1_ready_o,
   input  logic                 axis_s1_last_i,
   input  logic                 axis_s1_user_i,
   output logic [DATA_BITS-1:0] axis_m_data_o,
   output logic                 axis_m_valid_o,
   input  logic                 axis_m_ready_i,
   output logic                 axis_m_last_o,
   output logic                 axis_m_user_o,
   output logic [1:0]           grant_o,
   output logic                 frame_done_o,
   output logic [15:0]          drop_cnt_o
);

   typedef enum logic [0:0] {ST_IDLE, ST_BUSY} state_t;

   localparam logic [15:0] LAST_LINE = 16'(LINES_PER_FRAME - 1);

   state_t               state_q, state_d;
   logic [1:0]           grant_q, grant_d;
   logic                 last_grant_q, last_grant_d;
   logic [15:0]          line_cnt_q, line_cnt_d;
   logic [15:0]          drop_cnt_q, drop_cnt_d;
   logic                 frame_done_q, frame_done_d;
   logic                 m_valid_q;
   logic [DATA_BITS-1:0] m_data_q;
   logic                 m_last_q, m_user_q;

   logic                 slot_free;
   logic                 sel;
   logic                 beat_valid, beat_last, beat_user;
   logic [DATA_BITS-1:0] beat_data;
   logic                 accept;
   logic                 drop0, drop1;
   logic                 cand0, cand1;
   logic [16:0]          drop_sum;
   logic [15:0]          lines_before;

   always_comb begin
      slot_free  = !m_valid_q || axis_m_ready_i;
      sel        = grant_q[1];
      beat_valid = sel ? axis_s1_valid_i : axis_s0_valid_i;
      beat_last  = sel ? axis_s1_last_i  : axis_s0_last_i;
      beat_user  = sel ? axis_s1_user_i  : axis_s0_user_i;
      beat_data  = sel ? axis_s1_data_i  : axis_s0_data_i;
      drop0      = axis_s0_valid_i && !axis_s0_user_i;
      drop1      = axis_s1_valid_i && !axis_s1_user_i;
      cand0      = axis_s0_valid_i && axis_s0_user_i;
      cand1      = axis_s1_valid_i && axis_s1_user_i;
      drop_sum   = {1'b0, drop_cnt_q} + {16'b0, drop0} + {16'b0, drop1};
      // A SOF beat mid-frame restarts the line count from zero
      lines_before = beat_user ? 16'd0 : line_cnt_q;
   end

   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      last_grant_d    = last_grant_q;
      line_cnt_d      = line_cnt_q;
      drop_cnt_d      = drop_cnt_q;
      frame_done_d    = 1'b0;
      accept          = 1'b0;
      axis_s0_ready_o = 1'b0;
      axis_s1_ready_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            axis_s0_ready_o = !axis_s0_user_i;
            axis_s1_ready_o = !axis_s1_user_i;
            drop_cnt_d      = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (cand0 && cand1) begin
               grant_d = last_grant_q ? 2'b01 : 2'b10;
               state_d = ST_BUSY;
            end else if (cand0) begin
               grant_d = 2'b01;
               state_d = ST_BUSY;
            end else if (cand1) begin
               grant_d = 2'b10;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            axis_s0_ready_o = !sel && slot_free;
            axis_s1_ready_o = sel && slot_free;
            accept          = beat_valid && slot_free;
            if (accept) begin
               if (beat_last) begin
                  if (lines_before == LAST_LINE) begin
                     frame_done_d = 1'b1;
                     last_grant_d = sel;
                     line_cnt_d   = 16'd0;
                     grant_d      = 2'b00;
                     state_d      = ST_IDLE;
                  end else begin
                     line_cnt_d = lines_before + 16'd1;
                  end
               end else begin
                  line_cnt_d = lines_before;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase

      if (rst_i) begin
         axis_s0_ready_o = 1'b0;
         axis_s1_ready_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         grant_q      <= 2'b00;
         last_grant_q <= 1'b1;
         line_cnt_q   <= 16'd0;
         drop_cnt_q   <= 16'd0;
         frame_done_q <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_last_q     <= 1'b0;
         m_user_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         line_cnt_q   <= line_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         frame_done_q <= frame_done_d;
         if (slot_free) begin
            m_valid_q <= accept;
            if (accept) begin
               m_data_q <= beat_data;
               m_last_q <= beat_last;
               m_user_q <= beat_user;
            end
         end
      end
   end

   assign axis_m_data_o  = m_data_q;
   assign axis_m_valid_o = m_valid_q;
   assign axis_m_last_o  = m_last_q;
   assign axis_m_user_o  = m_user_q;
   assign grant_o        = grant_q;
   assign frame_done_o   = frame_done_q;
   assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - scoreboard bench for axis_frame_arbiter
module tb_axis_frame_arbiter;
   logic        clk = 0;
   logic        rst = 1;
   logic [23:0] s0_data = 0, s1_data = 0;
   logic        s0_valid = 0, s1_valid = 0, s0_last = 0, s1_last = 0, s0_user = 0, s1_user = 0;
   logic        s0_ready, s1_ready;
   logic [23:0] m_data;
   logic        m_valid, m_last, m_user;
   logic        m_ready = 1;
   logic [1:0]  grant;
   logic        frame_done;
   logic [15:0] drop_cnt;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int fd_cnt = 0;
   int pop_n = 0, first_pop = 0, last_pop = 0, stall_n = 0;
   logic [25:0] exp_q[$];
   logic [1:0]  grant_log[$];
   logic [1:0]  prev_g = 0;
   logic        prev_stall = 0;
   logic [25:0] prev_word = 0;

   axis_frame_arbiter #(.DATA_BITS(24), .LINES_PER_FRAME(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .axis_s0_data_i(s0_data), .axis_s0_valid_i(s0_valid), .axis_s0_ready_o(s0_ready),
      .axis_s0_last_i(s0_last), .axis_s0_user_i(s0_user),
      .axis_s1_data_i(s1_data), .axis_s1_valid_i(s1_valid), .axis_s1_ready_o(s1_ready),
      .axis_s1_last_i(s1_last), .axis_s1_user_i(s1_user),
      .axis_m_data_o(m_data), .axis_m_valid_o(m_valid), .axis_m_ready_i(m_ready),
      .axis_m_last_o(m_last), .axis_m_user_o(m_user),
      .grant_o(grant), .frame_done_o(frame_done), .drop_cnt_o(drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Monitor: scoreboard pops, stall stability, ready model, grant log, frame_done count
   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (grant != 2'b00 && grant != prev_g) grant_log.push_back(grant);
      prev_g = grant;
      if (!rst) begin
         if (prev_stall) begin
            chk("hold_valid", {31'b0, m_valid}, 32'd1);
            chk("hold_data", {6'b0, m_user, m_last, m_data}, {6'b0, prev_word});
         end
         if (grant == 2'b01) begin
            chk("s0_ready_busy", {31'b0, s0_ready}, {31'b0, (!m_valid || m_ready)});
            chk("s1_ready_held", {31'b0, s1_ready}, 32'd0);
         end
         if (grant == 2'b10) begin
            chk("s1_ready_busy", {31'b0, s1_ready}, {31'b0, (!m_valid || m_ready)});
            chk("s0_ready_held", {31'b0, s0_ready}, 32'd0);
         end
      end
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {6'b0, m_user, m_last, m_data}, 32'hDEAD_BEEF);
         end else begin
            chk("out_beat", {6'b0, m_user, m_last, m_data}, {6'b0, exp_q.pop_front()});
         end
         if (pop_n == 0) first_pop = cyc;
         last_pop = cyc;
         pop_n++;
      end
      if (m_valid && !m_ready) stall_n++;
      prev_stall = m_valid && !m_ready && !rst;
      prev_word  = {m_user, m_last, m_data};
   end

   task automatic drive(input int p, input logic v, input logic [23:0] d, input logic l, input logic u);
      if (p == 0) begin
         s0_valid = v; s0_data = d; s0_last = l; s0_user = u;
      end else begin
         s1_valid = v; s1_data = d; s1_last = l; s1_user = u;
      end
   endtask

   task automatic send(input int p, input logic [23:0] d, input logic l, input logic u);
      bit ok = 0;
      drive(p, 1'b1, d, l, u);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((p == 0 ? s0_ready : s1_ready) == 1'b1) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk); #1;
      drive(p, 1'b0, 24'd0, 1'b0, 1'b0);
      if (!ok) begin
         checks++; fails++;
         $display("FAIL send_timeout: port %0d data %0h not accepted within 200 cycles", p, d);
      end
   endtask

   function automatic logic [25:0] word(input logic [23:0] d, input logic l, input logic u);
      return {u, l, d};
   endfunction

   // One frame of 2 lines x 2 beats; data encodes port, frame and beat
   task automatic push_frame(input int p, input int f);
      for (int b = 0; b < 4; b++)
         exp_q.push_back(word(24'(p * 256 + f * 16 + b), (b == 1 || b == 3), (b == 0)));
   endtask

   task automatic send_frame(input int p, input int f);
      for (int b = 0; b < 4; b++)
         send(p, 24'(p * 256 + f * 16 + b), (b == 1 || b == 3), (b == 0));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1; m_ready = 1;
      drive(0, 1'b0, 24'd0, 1'b0, 1'b0);
      drive(1, 1'b0, 24'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      fd_cnt = 0; pop_n = 0; stall_n = 0;
      grant_log.delete();
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk(name, exp_q.size(), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   task automatic chk_grants(input string name, input logic [1:0] e[$]);
      chk({name, "_count"}, grant_log.size(), e.size());
      for (int i = 0; i < e.size() && i < grant_log.size(); i++)
         chk(name, {30'b0, grant_log[i]}, {30'b0, e[i]});
   endtask

   int c0;

   initial begin
      // Reset state, including readiness gated during reset
      @(posedge clk); #1;
      drive(0, 1'b1, 24'h5, 1'b0, 1'b0);
      @(negedge clk);
      chk("rst_s0_ready", {31'b0, s0_ready}, 32'd0);
      chk("rst_s1_ready", {31'b0, s1_ready}, 32'd0);
      chk("rst_grant", {30'b0, grant}, 32'd0);
      chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
      chk("rst_m_data", {8'b0, m_data}, 32'd0);
      chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
      chk("rst_drop", {16'b0, drop_cnt}, 32'd0);
      do_reset();

      // Single source: 8 beats, 2-cycle latency, one frame_done
      for (int i = 0; i < 8; i++) exp_q.push_back(word(24'(16'hA0 + i), (i == 3 || i == 7), (i == 0)));
      c0 = cyc;
      for (int i = 0; i < 8; i++) send(0, 24'(16'hA0 + i), (i == 3 || i == 7), (i == 0));
      drain("single_drain");
      chk("single_first_lat", first_pop - c0, 32'd2);
      chk("single_last_lat", last_pop - c0, 32'd9);
      chk("single_fd", fd_cnt, 32'd1);
      chk_grants("single_grant", '{2'b01});

      // Tie: round-robin s0, s1, s0, s1 with whole frames
      do_reset();
      push_frame(0, 0); push_frame(1, 0); push_frame(0, 1); push_frame(1, 1);
      fork
         begin send_frame(0, 0); send_frame(0, 1); end
         begin send_frame(1, 0); send_frame(1, 1); end
      join
      drain("tie_drain");
      chk("tie_fd", fd_cnt, 32'd4);
      chk_grants("tie_grant", '{2'b01, 2'b10, 2'b01, 2'b10});

      // Backpressure: output ready 1,0,0,1 mid-line
      do_reset();
      for (int i = 0; i < 8; i++) exp_q.push_back(word(24'(16'hB0 + i), (i == 3 || i == 7), (i == 0)));
      fork
         for (int i = 0; i < 8; i++) send(0, 24'(16'hB0 + i), (i == 3 || i == 7), (i == 0));
         begin
            repeat (3) @(posedge clk);
            #1 m_ready = 1;
            @(posedge clk); #1 m_ready = 0;
            @(posedge clk); #1 m_ready = 0;
            @(posedge clk); #1 m_ready = 1;
         end
      join
      drain("bp_drain");
      chk("bp_stalls", stall_n, 32'd2);
      chk("bp_fd", fd_cnt, 32'd1);

      // Orphans: 5 on s1 and 3 on s0 in the same cycles, then saturation
      do_reset();
      fork
         for (int i = 0; i < 5; i++) send(1, 24'(i), 1'b0, 1'b0);
         for (int i = 0; i < 3; i++) send(0, 24'(i), 1'b0, 1'b0);
      join
      @(negedge clk);
      chk("orphan_drop", {16'b0, drop_cnt}, 32'd8);
      chk("orphan_no_out", pop_n, 32'd0);
      @(posedge clk); #1;
      drive(0, 1'b1, 24'd0, 1'b0, 1'b0);
      drive(1, 1'b1, 24'd0, 1'b0, 1'b0);
      repeat (32763) @(posedge clk);
      @(negedge clk);
      chk("drop_near_sat", {16'b0, drop_cnt}, 32'd65534);
      @(negedge clk);
      chk("drop_sat", {16'b0, drop_cnt}, 32'hFFFF);
      repeat (3) @(negedge clk);
      chk("drop_sat_hold", {16'b0, drop_cnt}, 32'hFFFF);
      chk("sat_no_out", pop_n, 32'd0);

      // Truncated frame: restart after one line keeps grant, defers frame_done
      do_reset();
      for (int i = 0; i < 6; i++) exp_q.push_back(word(24'(16'hC0 + i), (i % 2 == 1), (i == 0 || i == 2)));
      for (int i = 0; i < 4; i++) send(0, 24'(16'hC0 + i), (i % 2 == 1), (i == 0 || i == 2));
      repeat (3) @(negedge clk);
      chk("trunc_no_fd", fd_cnt, 32'd0);
      chk("trunc_grant", {30'b0, grant}, 32'd1);
      @(posedge clk); #1;
      for (int i = 4; i < 6; i++) send(0, 24'(16'hC0 + i), (i % 2 == 1), 1'b0);
      drain("trunc_drain");
      chk("trunc_fd", fd_cnt, 32'd1);
      chk_grants("trunc_grant_log", '{2'b01});

      // Reset mid-frame, then a fresh SOF on s1
      do_reset();
      send(1, 24'h77, 1'b0, 1'b0);
      exp_q.push_back(word(24'hD0, 1'b0, 1'b1));
      exp_q.push_back(word(24'hD1, 1'b0, 1'b0));
      send(0, 24'hD0, 1'b0, 1'b1);
      send(0, 24'hD1, 1'b0, 1'b0);
      drive(0, 1'b1, 24'hD2, 1'b0, 1'b0);
      rst = 1;
      @(negedge clk);
      chk("midrst_ready", {31'b0, s0_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 0;
      drive(0, 1'b0, 24'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("midrst_grant", {30'b0, grant}, 32'd0);
      chk("midrst_valid", {31'b0, m_valid}, 32'd0);
      chk("midrst_drop", {16'b0, drop_cnt}, 32'd0);
      chk("midrst_queue", exp_q.size(), 32'd0);
      chk("midrst_no_fd", fd_cnt, 32'd0);
      grant_log.delete();
      @(posedge clk); #1;
      push_frame(1, 2);
      send_frame(1, 2);
      drain("midrst_drain");
      chk("midrst_fd", fd_cnt, 32'd1);
      chk_grants("midrst_grant_log", '{2'b10});

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
